// File: rtl/cache_pkg.sv
// Shared constants and state type for the cache-to-memory line adaptor.
package cache_pkg;

  localparam int S_LINE     = 256;
  localparam int S_BEAT     = 64;
  localparam int S_ADDR     = 32;
  localparam int BURST_LEN  = S_LINE / S_BEAT;
  localparam int LINE_OFF_W = $clog2(S_LINE / 8);
  localparam int BEAT_OFF_W = $clog2(S_BEAT / 8);
  localparam int CNT_W      = $clog2(BURST_LEN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } adaptor_state_t;

endpackage

// File: rtl/cacheline_adaptor.sv
// Converts 256-bit cache line fills/write-backs into four-beat 64-bit memory bursts.
// Optional: define CACHELINE_ADAPTOR_CWF_EN for critical-word-first line fills.
module cacheline_adaptor
  import cache_pkg::*;
#(
  parameter int S_LINE = cache_pkg::S_LINE,
  parameter int S_BEAT = cache_pkg::S_BEAT,
  parameter int S_ADDR = cache_pkg::S_ADDR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [S_LINE-1:0] line_i,
  output logic [S_LINE-1:0] line_o,
  input  logic [S_ADDR-1:0] address_i,
  input  logic              read_i,
  input  logic              write_i,
  output logic              resp_o,
  input  logic [S_BEAT-1:0] burst_i,
  output logic [S_BEAT-1:0] burst_o,
  output logic [S_ADDR-1:0] address_o,
  output logic              read_o,
  output logic              write_o,
  input  logic              resp_i
);

  localparam int BURST_LEN  = S_LINE / S_BEAT;
  localparam int LINE_OFF_W = $clog2(S_LINE / 8);
  localparam int BEAT_OFF_W = $clog2(S_BEAT / 8);
  localparam int CNT_W      = $clog2(BURST_LEN);

  typedef logic [BURST_LEN-1:0][S_BEAT-1:0] line_t;

  adaptor_state_t    state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  start_q, start_d;
  logic [S_ADDR-1:0] addr_q, addr_d;
  line_t             rline_q, rline_d;
  line_t             wline_q, wline_d;
  logic              last_beat;

  // Low address bits are discarded by the alignment below.
  logic unused_addr_bits;
  assign unused_addr_bits = ^address_i[LINE_OFF_W-1:0];

  // The burst ends when the counter is about to return to its starting slot.
  assign last_beat = resp_i && (CNT_W'(cnt_q + 1'b1) == start_q);

  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latches).
    state_d = state_q;
    cnt_d   = cnt_q;
    start_d = start_q;
    addr_d  = addr_q;
    rline_d = rline_q;
    wline_d = wline_q;

    unique case (state_q)
      IDLE: begin
        if (write_i) begin
          addr_d  = {address_i[S_ADDR-1:LINE_OFF_W], {LINE_OFF_W{1'b0}}};
          wline_d = line_i;
          cnt_d   = '0;
          start_d = '0;
          state_d = WR;
        end else if (read_i) begin
`ifdef CACHELINE_ADAPTOR_CWF_EN
          addr_d  = {address_i[S_ADDR-1:BEAT_OFF_W], {BEAT_OFF_W{1'b0}}};
          cnt_d   = address_i[LINE_OFF_W-1:BEAT_OFF_W];
          start_d = address_i[LINE_OFF_W-1:BEAT_OFF_W];
`else
          addr_d  = {address_i[S_ADDR-1:LINE_OFF_W], {LINE_OFF_W{1'b0}}};
          cnt_d   = '0;
          start_d = '0;
`endif
          state_d = RD;
        end
      end
      RD: begin
        if (resp_i) begin
          rline_d[cnt_q] = burst_i;
          cnt_d          = CNT_W'(cnt_q + 1'b1);
          if (last_beat) state_d = DONE;
        end
      end
      WR: begin
        if (resp_i) begin
          cnt_d = CNT_W'(cnt_q + 1'b1);
          if (last_beat) state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
    endcase
  end

  // NOTE: the line registers are datapath but are reset too, because line_o must read 0 after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      start_q <= '0;
      addr_q  <= '0;
      rline_q <= '0;
      wline_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      addr_q  <= addr_d;
      rline_q <= rline_d;
      wline_q <= wline_d;
    end
  end

  assign read_o    = (state_q == RD);
  assign write_o   = (state_q == WR);
  assign resp_o    = (state_q == DONE);
  assign address_o = addr_q;
  assign line_o    = rline_q;
  assign burst_o   = (state_q == WR) ? wline_q[cnt_q] : '0;

endmodule

// File: doc/cacheline_adaptor.md
# cacheline_adaptor

Bridges the 256-bit cache line interface of the cache controller and data array to the 64-bit burst memory port. On a line fill it collects a four-beat read burst and presents the assembled line for writing into the data array. On a write-back it takes a dirty line read out of the data array and sends it as a four-beat write burst. It sits between the cache and physical memory, one instance per cache.

## Interface
Parameters:
- S_LINE, 256, cache line width in bits; must equal the data array line width.
- S_BEAT, 64, memory burst beat width in bits.
- BURST_LEN, S_LINE/S_BEAT (4), beats per line; derived, not overridden.
- S_ADDR, 32, address width.

Ports (reset is asynchronous and active-low; `rst` is asserted at 0):
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- line_i  in  S_LINE  line to write back; sampled when the write is accepted.
- line_o  out  S_LINE  assembled fill line; valid while resp_o is high and held until the next fill starts.
- address_i  in  S_ADDR  request address from the cache.
- read_i  in  1  line fill request.
- write_i  in  1  write-back request.
- resp_o  out  1  one-cycle completion pulse.
- burst_i  in  S_BEAT  read beat from memory.
- burst_o  out  S_BEAT  write beat to memory.
- address_o  out  S_ADDR  memory address.
- read_o  out  1  memory read request.
- write_o  out  1  memory write request.
- resp_i  in  1  memory beat strobe.

## Operation
States:
- IDLE
  - read_i=1 latches address_i and goes to RD.
  - write_i=1 latches address_i and line_i and goes to WR.
  - If both are high, write wins and read_i is ignored; the cache re-issues the read.
- RD: read_o=1. Each cycle with resp_i=1 stores burst_i into beat slot `cnt` and increments `cnt`. On the last beat, go to DONE.
- WR: write_o=1 and burst_o = latched line beat `cnt`. Each resp_i=1 increments `cnt`. On the last beat, go to DONE.
- DONE: resp_o=1 for exactly one cycle, then return to IDLE.

Rules:
- Gaps in resp_i are legal; `cnt` advances only on resp_i=1.
- resp_i in IDLE or DONE is ignored.
- read_i or write_i seen outside IDLE is ignored; the cache holds its request until resp_o.
- address_o is the latched address with bits [log2(S_LINE/8)-1:0] cleared, i.e. line-aligned.
- `cnt` is log2(BURST_LEN) bits wide and wraps modulo BURST_LEN.
- Beat k occupies line bits [S_BEAT*k +: S_BEAT].

Reset (rst=0, also mid-burst):
- Go to IDLE immediately and clear `cnt`.
- read_o, write_o, resp_o, address_o, burst_o and line_o all reset to 0.
- An in-flight burst is abandoned; memory must also be reset.

## Timing
- All outputs are registered or decoded from state; there is no input-to-output combinational path.
- Request seen in cycle 0 → read_o or write_o high from cycle 1.
- Read/write drops in the cycle after the final resp_i, which is also the resp_o cycle.
- With back-to-back resp_i, resp_o is high in cycle BURST_LEN+1 (cycle 5).
- Earliest next request acceptance is the cycle after resp_o.
- burst_o changes the cycle after each accepted write beat.

## Configuration
- CACHELINE_ADAPTOR_CWF_EN (critical word first), **defined**, reads only:
  - address_o keeps the beat-aligned address (bits [log2(S_BEAT/8)-1:0] cleared).
  - `cnt` starts at the requested beat index and wraps BURST_LEN-1 → 0.
  - The burst ends after BURST_LEN beats, so the line is still complete at resp_o.
- **Undefined:** reads start at beat 0 with a line-aligned address_o.
- Writes always start at beat 0 in both builds.

## Structure
- Shared package `cache_pkg` holds:
  - S_LINE, S_BEAT, BURST_LEN, and the offset width constants.
  - `adaptor_state_t` enum {IDLE, RD, WR, DONE}.
- No sub-module: a single FSM, a beat counter and two line registers.

## Test plan
- **Reset mid-read:** rst=0 during beat 2 → all outputs 0, state IDLE. A following fill completes correctly.
- **Line fill:**
  - Stimulus: read_i at address 0x0000_1234; beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on consecutive resp_i.
  - Response: address_o=0x0000_1220, resp_o in cycle 5, line_o = {0x44..44, 0x33..33, 0x22..22, 0x11..11}.
- **Write-back:**
  - Stimulus: write_i with line_i = {0xDD..DD, 0xCC..CC, 0xBB..BB, 0xAA..AA}.
  - Response: burst_o = 0xAA..AA, 0xBB..BB, 0xCC..CC, 0xDD..DD in order; one resp_o.
- **Gapped resp_i:** pattern 1,0,0,1,1,0,1 → the line is still correct and resp_o comes 1 cycle after the 4th strobe.
- **Simultaneous read_i and write_i:** → the write burst is performed and read_o stays 0.
- **CWF_EN defined:**
  - Stimulus: read at 0x0000_1230.
  - Response: address_o=0x0000_1230; beat 0 of the burst lands in slot 2, then slots 3, 0, 1.
